// File: rtl/wb_surfbridge_rackctl_pkg.sv
// Shared widths, state encoding and helpers for the SURF RACKctl bridge.
// Also imported by the rackctl PHY so both sides agree on transaction layout.
package surf_rackctl_pkg;

    localparam int RACKCTL_READ_BIT = 23;
    localparam int RACKCTL_ADDR_W   = 24;
    localparam int RACKCTL_DATA_W   = 32;
    localparam int WB_ADDR_W        = 23;
    localparam int ERR_CNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        ACK,
        ERR,
        MODE_SET,
        MODE_WAIT
    } state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(
        input logic [ERR_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_surfbridge_rackctl_watchdog.sv
// Free-running wait counter; expires once it has counted 2^TIMEOUT_BITS clocks.
// Clear wins over enable so every wait starts from zero.
module rackctl_watchdog #(
    parameter int TIMEOUT_BITS = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TIMEOUT_BITS-1:0] cnt_q;
    logic [TIMEOUT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = &cnt_q;

endmodule

// File: rtl/wb_surfbridge_rackctl.sv
// Wishbone classic slave turning SURF register accesses into single RACKctl
// transactions, and sequencing RACKctl mode switches ahead of bus traffic.
module wb_surfbridge_rackctl
    import surf_rackctl_pkg::*;
#(
    parameter int          TIMEOUT_BITS = 10,
    parameter logic [31:0] ERR_DATA     = 32'hFFFF_FFFF
) (
    input  logic                      sysclk_i,
    input  logic                      rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [WB_ADDR_W-1:0]      wb_adr_i,
    input  logic [RACKCTL_DATA_W-1:0] wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [RACKCTL_DATA_W-1:0] wb_dat_o,
    input  logic                      mode_req_i,
    output logic                      mode_o,
    output logic                      mode_busy_o,
    output logic [RACKCTL_ADDR_W-1:0] txn_addr_o,
    output logic [RACKCTL_DATA_W-1:0] txn_data_o,
    output logic                      txn_start_o,
    input  logic [RACKCTL_DATA_W-1:0] txn_resp_i,
    input  logic                      txn_done_i,
    input  logic                      txn_err_i,
    output logic [ERR_CNT_W-1:0]      err_count_o
);

    state_e                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic                      busy_q, busy_d;
    logic [RACKCTL_ADDR_W-1:0] addr_q, addr_d;
    logic [RACKCTL_DATA_W-1:0] data_q, data_d;
    logic [RACKCTL_DATA_W-1:0] rdat_q, rdat_d;
    logic [ERR_CNT_W-1:0]      ecnt_q, ecnt_d;

    logic waiting;
    logic wd_expired;

    assign waiting = (state_q == WAIT) || (state_q == MODE_WAIT);

    rackctl_watchdog #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_wd (
        .clk_i    (sysclk_i),
        .rst_i    (rst_i),
        .clear_i  (!waiting),
        .enable_i (waiting),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdat_d  = rdat_q;
        ecnt_d  = ecnt_q;
        unique case (state_q)
            IDLE: begin
                // Mode switches pre-empt any pending bus access
                if (mode_req_i != mode_q) begin
                    state_d = MODE_SET;
                end else if (wb_cyc_i && wb_stb_i) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (wb_sel_i != 4'hF) begin
                    state_d = ERR;
                    if (!wb_we_i) begin
                        rdat_d = ERR_DATA;
                    end
                end else begin
                    addr_d  = {~wb_we_i, wb_adr_i};
                    if (wb_we_i) begin
                        data_d = wb_dat_i;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Error (PHY or watchdog) takes precedence over done
                if (txn_err_i || wd_expired) begin
                    state_d = ERR;
                    if (addr_q[RACKCTL_READ_BIT]) begin
                        rdat_d = ERR_DATA;
                    end
                end else if (txn_done_i) begin
                    state_d = ACK;
                    if (addr_q[RACKCTL_READ_BIT]) begin
                        rdat_d = txn_resp_i;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            ERR: begin
                ecnt_d  = sat_inc(ecnt_q);
                state_d = IDLE;
            end
            MODE_SET: begin
                mode_d  = mode_req_i;
                busy_d  = 1'b1;
                state_d = MODE_WAIT;
            end
            MODE_WAIT: begin
                if (txn_done_i || txn_err_i || wd_expired) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (txn_err_i || wd_expired) begin
                        ecnt_d = sat_inc(ecnt_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdat_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdat_q  <= rdat_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Terminations are suppressed once the master abandons the cycle
    assign wb_ack_o    = (state_q == ACK) && wb_cyc_i;
    assign wb_err_o    = (state_q == ERR) && wb_cyc_i;
    assign wb_dat_o    = rdat_q;
    assign mode_o      = mode_q;
    assign mode_busy_o = busy_q;
    assign txn_addr_o  = addr_q;
    assign txn_data_o  = data_q;
    assign txn_start_o = (state_q == ISSUE);
    assign err_count_o = ecnt_q;

endmodule

// File: tb/tb_wb_surfbridge_rackctl.sv
// Directed bench for wb_surfbridge_rackctl with a small behavioural PHY.
module tb_wb_surfbridge_rackctl;

    localparam int TB_TO  = 7;
    localparam int BUDGET = 1000;

    logic        sysclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [22:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_dat_o;
    logic        mode_req_i = 1'b0;
    logic        mode_o;
    logic        mode_busy_o;
    logic [23:0] txn_addr_o;
    logic [31:0] txn_data_o;
    logic        txn_start_o;
    logic [31:0] txn_resp_i = '0;
    logic        txn_done_i = 1'b0;
    logic        txn_err_i = 1'b0;
    logic [15:0] err_count_o;

    int total = 0;
    int bad = 0;

    // PHY model knobs: kind 0 done, 1 err, 2 silent, 3 done+err
    int          phy_kind = 0;
    int          phy_delay = 4;
    logic [31:0] phy_resp = '0;
    int          phy_cnt = 0;
    logic        phy_busy = 1'b0;
    logic        mode_prev = 1'b0;
    int          starts = 0;
    int          dones = 0;

    wb_surfbridge_rackctl #(
        .TIMEOUT_BITS(TB_TO),
        .ERR_DATA    (32'hFFFF_FFFF)
    ) dut (
        .sysclk_i   (sysclk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_dat_o   (wb_dat_o),
        .mode_req_i (mode_req_i),
        .mode_o     (mode_o),
        .mode_busy_o(mode_busy_o),
        .txn_addr_o (txn_addr_o),
        .txn_data_o (txn_data_o),
        .txn_start_o(txn_start_o),
        .txn_resp_i (txn_resp_i),
        .txn_done_i (txn_done_i),
        .txn_err_i  (txn_err_i),
        .err_count_o(err_count_o)
    );

    always #4 sysclk_i = ~sysclk_i;

    always @(posedge sysclk_i) begin
        txn_done_i <= 1'b0;
        txn_err_i  <= 1'b0;
        if (txn_start_o) starts <= starts + 1;
        if (rst_i) begin
            phy_busy  <= 1'b0;
            mode_prev <= 1'b0;
        end else if (txn_start_o || (mode_o != mode_prev)) begin
            mode_prev <= mode_o;
            phy_busy  <= 1'b1;
            phy_cnt   <= phy_delay;
        end else if (phy_busy) begin
            if (phy_cnt <= 1) begin
                phy_busy <= 1'b0;
                if (phy_kind == 0 || phy_kind == 3) begin
                    txn_done_i <= 1'b1;
                    txn_resp_i <= phy_resp;
                    dones      <= dones + 1;
                end
                if (phy_kind == 1 || phy_kind == 3) txn_err_i <= 1'b1;
            end else begin
                phy_cnt <= phy_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic wb_access(
        input  logic        we,
        input  logic [22:0] adr,
        input  logic [31:0] dat,
        input  logic [3:0]  sel,
        output logic        got_ack,
        output logic        got_err,
        output logic [31:0] rdata,
        output int          n
    );
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        n = 0;
        got_ack = 1'b0;
        got_err = 1'b0;
        rdata = '0;
        while (n < BUDGET && !got_ack && !got_err) begin
            tick();
            n++;
            got_ack = wb_ack_o;
            got_err = wb_err_o;
            rdata   = wb_dat_o;
        end
        tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", wb_ack_o); end
        total++; if (wb_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", wb_err_o); end
        total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", wb_dat_o); end
        total++; if (mode_o !== 1'b0) begin bad++; $display("FAIL rst_mode got=%b exp=0", mode_o); end
        total++; if (mode_busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", mode_busy_o); end
        total++; if (txn_addr_o !== 24'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", txn_addr_o); end
        total++; if (txn_start_o !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", txn_start_o); end
        total++; if (err_count_o !== 16'h0) begin bad++; $display("FAIL rst_ecnt got=%h exp=0", err_count_o); end
    endtask

    task automatic test_write();
        logic a, e; logic [31:0] d; int n, s0;
        phy_kind = 0; phy_delay = 80; s0 = starts;
        wb_access(1'b1, 23'h000123, 32'hDEADBEEF, 4'hF, a, e, d, n);
        total++; if (a !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b/%b exp=1/0", a, e); end
        total++; if (n != 84) begin bad++; $display("FAIL wr_latency got=%0d exp=84", n); end
        total++; if (txn_addr_o !== 24'h000123) begin bad++; $display("FAIL wr_addr got=%h exp=000123", txn_addr_o); end
        total++; if (txn_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", txn_data_o); end
        total++; if (starts - s0 != 1) begin bad++; $display("FAIL wr_starts got=%0d exp=1", starts - s0); end
    endtask

    task automatic test_read();
        logic a, e; logic [31:0] d; int n;
        phy_kind = 0; phy_delay = 5; phy_resp = 32'h12345678;
        wb_access(1'b0, 23'h000010, 32'h0, 4'hF, a, e, d, n);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b exp=1", a); end
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL rd_dat got=%h exp=12345678", d); end
        total++; if (n != 9) begin bad++; $display("FAIL rd_latency got=%0d exp=9", n); end
        total++; if (txn_addr_o !== 24'h800010) begin bad++; $display("FAIL rd_addr got=%h exp=800010", txn_addr_o); end
        total++; if (txn_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_datahold got=%h exp=deadbeef", txn_data_o); end
    endtask

    task automatic test_bad_sel();
        logic a, e; logic [31:0] d; int n, s0;
        s0 = starts;
        wb_access(1'b1, 23'h000777, 32'h11111111, 4'h3, a, e, d, n);
        total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL sel_err got=%b/%b exp=1/0", e, a); end
        total++; if (n > 2) begin bad++; $display("FAIL sel_latency got=%0d exp<=2", n); end
        total++; if (starts != s0) begin bad++; $display("FAIL sel_nostart got=%0d exp=%0d", starts, s0); end
        total++; if (err_count_o !== 16'd1) begin bad++; $display("FAIL sel_ecnt got=%0d exp=1", err_count_o); end
        total++; if (txn_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL sel_datahold got=%h exp=deadbeef", txn_data_o); end
    endtask

    task automatic test_phy_err();
        logic a, e; logic [31:0] d; int n;
        phy_kind = 1; phy_delay = 3;
        wb_access(1'b0, 23'h000044, 32'h0, 4'hF, a, e, d, n);
        total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL perr_err got=%b/%b exp=1/0", e, a); end
        total++; if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL perr_dat got=%h exp=ffffffff", d); end
        total++; if (err_count_o !== 16'd2) begin bad++; $display("FAIL perr_ecnt got=%0d exp=2", err_count_o); end
    endtask

    task automatic test_mode_switch();
        int n, s0; logic saw;
        phy_kind = 0; phy_delay = 6; phy_resp = 32'hCAFEF00D; s0 = starts;
        mode_req_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 23'h000020; wb_sel_i = 4'hF;
        tick();
        tick();
        total++; if (mode_o !== 1'b1) begin bad++; $display("FAIL mode_set got=%b exp=1", mode_o); end
        total++; if (mode_busy_o !== 1'b1) begin bad++; $display("FAIL mode_busy got=%b exp=1", mode_busy_o); end
        n = 0; saw = 1'b0;
        while (mode_busy_o && n < 200) begin tick(); n++; saw |= wb_ack_o | wb_err_o; end
        total++; if (mode_busy_o !== 1'b0) begin bad++; $display("FAIL mode_done got=%b exp=0", mode_busy_o); end
        total++; if (saw !== 1'b0 || starts != s0) begin bad++; $display("FAIL mode_stall ack=%b starts=%0d exp=0/%0d", saw, starts, s0); end
        n = 0;
        while (!wb_ack_o && !wb_err_o && n < 200) begin tick(); n++; end
        total++; if (wb_ack_o !== 1'b1) begin bad++; $display("FAIL stalled_ack got=%b exp=1", wb_ack_o); end
        total++; if (wb_dat_o !== 32'hCAFEF00D) begin bad++; $display("FAIL stalled_dat got=%h exp=cafef00d", wb_dat_o); end
        total++; if (txn_addr_o !== 24'h800020) begin bad++; $display("FAIL stalled_addr got=%h exp=800020", txn_addr_o); end
        total++; if (starts - s0 != 1) begin bad++; $display("FAIL stalled_start got=%0d exp=1", starts - s0); end
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        s0 = starts;
        mode_req_i = 1'b0;
        n = 0;
        while (!mode_busy_o && n < 10) begin tick(); n++; end
        total++; if (mode_busy_o !== 1'b1) begin bad++; $display("FAIL mode0_busy got=%b exp=1", mode_busy_o); end
        n = 0;
        while (mode_busy_o && n < 200) begin tick(); n++; end
        total++; if (mode_o !== 1'b0 || mode_busy_o !== 1'b0) begin bad++; $display("FAIL mode0 got=%b/%b exp=0/0", mode_o, mode_busy_o); end
        total++; if (err_count_o !== 16'd2 || starts != s0) begin bad++; $display("FAIL mode0_side ecnt=%0d starts=%0d exp=2/%0d", err_count_o, starts, s0); end
    endtask

    task automatic test_timeout();
        logic a, e; logic [31:0] d; int n;
        phy_kind = 2; phy_delay = 2;
        wb_access(1'b0, 23'h000055, 32'h0, 4'hF, a, e, d, n);
        total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b exp=1/0", e, a); end
        total++; if (n != 3 + (1 << TB_TO)) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", n, 3 + (1 << TB_TO)); end
        total++; if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL to_dat got=%h exp=ffffffff", d); end
        total++; if (err_count_o !== 16'd3) begin bad++; $display("FAIL to_ecnt got=%0d exp=3", err_count_o); end
    endtask

    task automatic test_done_err();
        logic a, e; logic [31:0] d; int n;
        phy_kind = 3; phy_delay = 4;
        wb_access(1'b1, 23'h000066, 32'hA5A5A5A5, 4'hF, a, e, d, n);
        total++; if (e !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL de_err got=%b/%b exp=1/0", e, a); end
        total++; if (err_count_o !== 16'd4) begin bad++; $display("FAIL de_ecnt got=%0d exp=4", err_count_o); end
        total++; if (txn_data_o !== 32'hA5A5A5A5) begin bad++; $display("FAIL de_data got=%h exp=a5a5a5a5", txn_data_o); end
    endtask

    task automatic test_cyc_drop();
        logic a, e, saw; logic [31:0] d; int n, d0;
        phy_kind = 0; phy_delay = 20; d0 = dones;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 23'h000099; wb_dat_i = 32'h0BADF00D; wb_sel_i = 4'hF;
        repeat (6) tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(); saw |= wb_ack_o | wb_err_o; end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL drop_noack got=%b exp=0", saw); end
        total++; if (dones - d0 != 1) begin bad++; $display("FAIL drop_phydone got=%0d exp=1", dones - d0); end
        phy_delay = 2;
        wb_access(1'b1, 23'h0000AA, 32'h13579BDF, 4'hF, a, e, d, n);
        total++; if (a !== 1'b1 || n != 6) begin bad++; $display("FAIL drop_next ack=%b n=%0d exp=1/6", a, n); end
        total++; if (txn_data_o !== 32'h13579BDF) begin bad++; $display("FAIL drop_next_data got=%h exp=13579bdf", txn_data_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_sel();
        test_phy_err();
        test_mode_switch();
        test_timeout();
        test_done_err();
        test_cyc_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_surfbridge_rackctl.md
Name: wb_surfbridge_rackctl

Overview:
Wishbone classic slave that turns register reads and writes aimed at one SURF into single RACKctl transactions. It drives the rackctl PHY's static addr/data/start inputs and waits for that PHY's done/err flags. It also sequences RACKctl mode switches (mode 0 half-duplex ↔ mode 1 receive-only) as pseudo-transactions that must complete before any new bus access is accepted. One instance sits per SURF, between the TURFIO Wishbone interconnect and the rackctl PHY.

Parameters:
TIMEOUT_BITS, 10, width of the watchdog counter; the bridge forces an error after 2^TIMEOUT_BITS clocks waiting on the PHY.
ERR_DATA, 32'hFFFFFFFF, value returned on wb_dat_o for a failed read.

Ports:
sysclk_i  in  1  system clock (125 MHz)
rst_i  in  1  synchronous, active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  23  SURF register word address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; only 4'hF is legal
wb_ack_o  out  1  single-cycle acknowledge
wb_err_o  out  1  single-cycle error terminate
wb_dat_o  out  32  read data
mode_req_i  in  1  requested RACKctl mode, from a control register
mode_o  out  1  mode presented to the PHY mode_i
mode_busy_o  out  1  high while a mode switch is in flight
txn_addr_o  out  24  {read flag, wb_adr_i}; bit 23 = 1 means read
txn_data_o  out  32  write data to the PHY
txn_start_o  out  1  one-cycle start pulse
txn_resp_i  in  32  PHY read data
txn_done_i  in  1  PHY completion flag
txn_err_i  in  1  PHY timeout flag
err_count_o  out  16  saturating count of failed transactions and mode switches

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog 0.
- States: IDLE, CHECK, ISSUE, WAIT, ACK, ERR, MODE_SET, MODE_WAIT.
- IDLE:
  - If mode_req_i != mode_o, go to MODE_SET. Mode switches take priority over a pending bus access.
  - Else if wb_cyc_i && wb_stb_i, go to CHECK.
- CHECK:
  - If wb_sel_i != 4'hF, go to ERR. No PHY traffic is generated.
  - Else latch txn_addr_o <= {~wb_we_i, wb_adr_i}, and latch txn_data_o <= wb_dat_i (writes only; the value is held on reads). Go to ISSUE.
- ISSUE: txn_start_o = 1 for exactly one cycle, then go to WAIT.
- txn_addr_o and txn_data_o are held static from CHECK until the bridge next leaves IDLE. They must not change while the PHY is busy.
- WAIT:
  - txn_done_i → ACK. On a read, wb_dat_o <= txn_resp_i.
  - txn_err_i → ERR.
  - Watchdog reaching all-ones → ERR.
  - If done and err arrive in the same cycle, err wins.
- ACK: wb_ack_o = 1 for one cycle, then IDLE. Minimum latency from stb to ack is 4 clocks plus PHY time.
- ERR:
  - wb_err_o = 1 for one cycle.
  - On a read, wb_dat_o <= ERR_DATA.
  - err_count_o increments and saturates at 16'hFFFF.
  - Return to IDLE.
- MODE_SET:
  - mode_o <= mode_req_i and mode_busy_o <= 1.
  - No txn_start_o is issued; the PHY treats the mode change itself as a transaction.
  - Go to MODE_WAIT.
- MODE_WAIT:
  - Wait for txn_done_i or txn_err_i, or watchdog expiry.
  - On err or timeout, increment err_count_o.
  - Clear mode_busy_o and go to IDLE.
  - A stb that arrives meanwhile is stalled (no ack) and is not lost.
- mode_req_i toggling during MODE_WAIT: sampled again only in IDLE, so back-to-back switches are serialised.
- wb_cyc_i dropped mid-transaction: the PHY transaction still runs to completion, and the ack/err is suppressed. wb_ack_o and wb_err_o are gated with wb_cyc_i.
- Watchdog: counts in WAIT and MODE_WAIT, and is cleared in every other state.
- rst_i mid-transaction: returns to IDLE with mode_o = 0. The PHY has no reset, so the integrator must hold off rst_i while mode_busy_o or a transaction is active, or accept a resync.

Decomposition:
- Package surf_rackctl_pkg holds:
  - state enum;
  - RACKCTL_READ_BIT = 23;
  - RACKCTL_ADDR_W = 24;
  - RACKCTL_DATA_W = 32.
- The surf_rackctl_phy can import the same widths.
- The watchdog is a natural sub-module: rackctl_watchdog (clear/enable inputs, expired output).

Test Plan:
- Write: adr=0x000123, dat=0xDEADBEEF, sel=F; PHY model asserts done 80 clocks after start → txn_addr_o=0x000123, txn_data_o=0xDEADBEEF, a single start pulse, then one wb_ack_o.
- Read: adr=0x000010; model returns txn_resp_i=0x12345678 with done → txn_addr_o=0x800010, wb_dat_o=0x12345678, wb_ack_o.
- sel=4'h3 write → wb_err_o within 2 clocks, no txn_start_o, err_count_o=1.
- PHY asserts txn_err_i on a read → wb_err_o, wb_dat_o=0xFFFFFFFF, err_count_o increments. Then a silent PHY with TIMEOUT_BITS=4 → err on the 16th wait clock.
- mode_req_i 0→1 with stb asserted the same cycle → mode_o=1 and mode_busy_o=1, no start pulse; after done, the stalled read is issued normally. Then 1→0 is acked by done.
- wb_cyc_i dropped during WAIT → no ack, the PHY transaction completes, and the next access succeeds.
